// File: rtl/spi_regfile_if.sv
// ============================================================================
// Module   : spi_regfile_if
// Brief    : SPI pin bundle (sclk/COPI/cs/CIPO) shared by controller and regfile.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spi_regfile_if;
  logic sclk;
  logic COPI;
  logic cs;
  logic CIPO;

  modport master (output sclk, output COPI, output cs, input CIPO);
  modport slave  (input sclk, input COPI, input cs, output CIPO);
endinterface

`default_nettype wire

// File: rtl/spi_regfile.sv
// ============================================================================
// Module   : spi_regfile
// Brief    : SPI mode-0 peripheral exposing a small register file; frames are
//            {rw, addr, data} MSB first. Readback built when SPI_READBACK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  spi_regfile_if.slave                    spi,
  output logic [NUM_REGS*DATA_W-1:0]      regs_out,
  output logic                            wr_stb,
  output logic [ADDR_W-1:0]               wr_addr
);

  localparam int c_FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);
  // The rw bit is shifted out before data completes, so only the wider field is kept.
  localparam int c_SH_W    = (ADDR_W + 1 > DATA_W) ? (ADDR_W + 1) : DATA_W;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HDR  = 2'd1;
  localparam logic [1:0] c_ST_DATA = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  logic [2:0]                 r_sclk_s, r_copi_s, r_cs_s;
  logic [1:0]                 r_state, w_next;
  logic [c_CNT_W-1:0]         r_bit_cnt;
  logic [c_SH_W-2:0]          r_shift;
  logic [c_SH_W-1:0]          w_shift_next;
  logic [ADDR_W-1:0]          r_addr, w_hdr_addr;
  logic                       r_rw, w_hdr_rw;
  logic [DATA_W-1:0]          r_data;
  logic                       r_pending;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic                       w_sclk_rise, w_cs_fall, w_cs_rise, w_copi;
  logic                       w_start, w_shift_en, w_hdr_done, w_data_done;
  logic                       w_wr_hit, w_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 3'b000;
      r_copi_s <= 3'b000;
      r_cs_s   <= 3'b111;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi.sclk};
      r_copi_s <= {r_copi_s[1:0], spi.COPI};
      r_cs_s   <= {r_cs_s[1:0], spi.cs};
    end
  end

  assign w_sclk_rise  = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_cs_fall    = ~r_cs_s[1] & r_cs_s[2];
  assign w_cs_rise    = r_cs_s[1] & ~r_cs_s[2];
  assign w_copi       = r_copi_s[1];
  assign w_shift_next = {r_shift, w_copi};
  assign w_hdr_addr   = w_shift_next[ADDR_W-1:0];
  assign w_hdr_rw     = w_shift_next[ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: if (w_cs_fall) w_next = c_ST_HDR;
        c_ST_HDR:  if (w_sclk_rise && r_bit_cnt == c_CNT_W'(ADDR_W)) w_next = c_ST_DATA;
        c_ST_DATA: if (w_sclk_rise && r_bit_cnt == c_CNT_W'(c_FRAME_W - 1)) w_next = c_ST_DONE;
        default:   w_next = r_state;
      endcase
    end
  end

  // A cs rise in the same clk as a sclk rise suppresses the shift, so the frame aborts.
  always_comb begin
    w_start     = (r_state == c_ST_IDLE) && w_cs_fall;
    w_shift_en  = w_sclk_rise && !w_cs_rise &&
                  ((r_state == c_ST_HDR) || (r_state == c_ST_DATA));
    w_hdr_done  = w_shift_en && (r_state == c_ST_HDR) &&
                  (r_bit_cnt == c_CNT_W'(ADDR_W));
    w_data_done = w_shift_en && (r_state == c_ST_DATA) &&
                  (r_bit_cnt == c_CNT_W'(c_FRAME_W - 1));
    w_wr_hit    = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (r_addr == ADDR_W'(n)) w_wr_hit = 1'b1;
    end
    w_commit    = (r_state == c_ST_DONE) && r_pending && r_rw && w_wr_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_data    <= '0;
      r_pending <= 1'b0;
      r_regs    <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
    end else begin
      if (w_start) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_rw      <= 1'b0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
        r_shift   <= w_shift_next[c_SH_W-2:0];
      end
      if (w_hdr_done) begin
        r_addr <= w_hdr_addr;
        r_rw   <= w_hdr_rw;
      end
      if (w_data_done) r_data <= w_shift_next[DATA_W-1:0];
      r_pending <= w_data_done;
      wr_stb    <= w_commit;
      if (w_commit) wr_addr <= r_addr;
      for (int n = 0; n < NUM_REGS; n++) begin
        if (w_commit && r_addr == ADDR_W'(n)) r_regs[n*DATA_W +: DATA_W] <= r_data;
      end
    end
  end

  assign regs_out = r_regs;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] r_rd_shift, w_rd_word;
  logic              r_cipo, w_sclk_fall, w_cipo_shift;

  assign w_sclk_fall  = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_cipo_shift = w_sclk_fall && !w_cs_rise && (r_state == c_ST_DATA) && !r_rw;

  always_comb begin
    w_rd_word = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (w_hdr_addr == ADDR_W'(n)) w_rd_word = r_regs[n*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_shift <= '0;
      r_cipo     <= 1'b0;
    end else if (w_hdr_done) begin
      r_rd_shift <= w_rd_word;
      r_cipo     <= 1'b0;
    end else if (w_cipo_shift) begin
      r_cipo     <= r_rd_shift[DATA_W-1];
      r_rd_shift <= r_rd_shift << 1;
    end else if (r_state == c_ST_IDLE) begin
      r_cipo     <= 1'b0;
    end
  end

  assign spi.CIPO = r_cipo && !r_rw &&
                    ((r_state == c_ST_DATA) || (r_state == c_ST_DONE));
`else
  assign spi.CIPO = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile.sv
// ============================================================================
// Module   : tb_spi_regfile
// Brief    : Directed bench for spi_regfile (default build plus a wide instance).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_regfile;

  localparam time HALF = 50ns;

  logic        clk;
  logic        rst_n;
  logic [39:0] regs_out0;
  logic        wr_stb0;
  logic [6:0]  wr_addr0;
  logic [255:0] regs_out1;
  logic        wr_stb1;
  logic [3:0]  wr_addr1;

  int checks = 0;
  int errors = 0;
  int stb0_cnt = 0;
  int stb1_cnt = 0;
  logic [6:0] stb0_addr = '0;

  spi_regfile_if bus0 ();
  spi_regfile_if bus1 ();

  spi_regfile u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (bus0.slave),
    .regs_out (regs_out0),
    .wr_stb   (wr_stb0),
    .wr_addr  (wr_addr0)
  );

  spi_regfile #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (bus1.slave),
    .regs_out (regs_out1),
    .wr_stb   (wr_stb1),
    .wr_addr  (wr_addr1)
  );

  initial clk = 1'b0;
  always #5ns clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb0) begin
      stb0_cnt++;
      stb0_addr = wr_addr0;
    end
    if (wr_stb1) stb1_cnt++;
  end

  // Sends the first nsend bits of an nbits frame, MSB first; CIPO sampled before each rise.
  task automatic spi_xfer(input int sel, input logic [31:0] frame, input int nbits,
                          input int nsend, output logic [31:0] rx);
    logic b;
    rx = '0;
    if (sel == 0) bus0.cs = 1'b0; else bus1.cs = 1'b0;
    #HALF;
    for (int i = 0; i < nsend; i++) begin
      b = frame[nbits-1-i];
      if (sel == 0) bus0.COPI = b; else bus1.COPI = b;
      #HALF;
      rx[nbits-1-i] = (sel == 0) ? bus0.CIPO : bus1.CIPO;
      if (sel == 0) bus0.sclk = 1'b1; else bus1.sclk = 1'b1;
      #HALF;
      if (sel == 0) bus0.sclk = 1'b0; else bus1.sclk = 1'b0;
    end
    #HALF;
    if (sel == 0) begin bus0.cs = 1'b1; bus0.COPI = 1'b0; end
    else begin bus1.cs = 1'b1; bus1.COPI = 1'b0; end
    #HALF;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (regs_out0 !== 40'h0) begin errors++; $display("FAIL reset_regs got=%h exp=0", regs_out0); end
    checks++; if (wr_stb0 !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b exp=0", wr_stb0); end
    checks++; if (wr_addr0 !== 7'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", wr_addr0); end
    checks++; if (bus0.CIPO !== 1'b0) begin errors++; $display("FAIL reset_cipo got=%b exp=0", bus0.CIPO); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] rx;
    int s0;
    s0 = stb0_cnt;
    spi_xfer(0, 32'h82A5, 16, 16, rx);
    checks++; if (regs_out0 !== 40'h0000A50000) begin errors++; $display("FAIL write_regs got=%h exp=0000a50000", regs_out0); end
    checks++; if (stb0_cnt - s0 !== 1) begin errors++; $display("FAIL write_stb_count got=%0d exp=1", stb0_cnt - s0); end
    checks++; if (stb0_addr !== 7'h02) begin errors++; $display("FAIL write_stb_addr got=%h exp=02", stb0_addr); end
    checks++; if (rx[15:0] !== 16'h0) begin errors++; $display("FAIL write_cipo got=%h exp=0000", rx[15:0]); end
  endtask

  task automatic test_write_oob();
    logic [31:0] rx;
    int s0;
    s0 = stb0_cnt;
    spi_xfer(0, 32'hFFFF, 16, 16, rx);
    checks++; if (regs_out0 !== 40'h0000A50000) begin errors++; $display("FAIL oob_regs got=%h exp=0000a50000", regs_out0); end
    checks++; if (stb0_cnt - s0 !== 0) begin errors++; $display("FAIL oob_stb got=%0d exp=0", stb0_cnt - s0); end
  endtask

  task automatic test_readback();
    logic [31:0] rx;
    int s0;
    spi_xfer(0, 32'h843C, 16, 16, rx);
    checks++; if (regs_out0 !== 40'h3C00A50000) begin errors++; $display("FAIL rb_write got=%h exp=3c00a50000", regs_out0); end
    s0 = stb0_cnt;
    spi_xfer(0, 32'h0400, 16, 16, rx);
`ifdef SPI_READBACK_EN
    checks++; if (rx[7:0] !== 8'h3C) begin errors++; $display("FAIL rb_data got=%h exp=3c", rx[7:0]); end
    checks++; if (rx[15:8] !== 8'h00) begin errors++; $display("FAIL rb_hdr_cipo got=%h exp=00", rx[15:8]); end
`else
    checks++; if (rx[15:0] !== 16'h0) begin errors++; $display("FAIL rb_disabled got=%h exp=0000", rx[15:0]); end
`endif
    checks++; if (stb0_cnt - s0 !== 0) begin errors++; $display("FAIL rb_stb got=%0d exp=0", stb0_cnt - s0); end
    checks++; if (regs_out0 !== 40'h3C00A50000) begin errors++; $display("FAIL rb_regs got=%h exp=3c00a50000", regs_out0); end
    spi_xfer(0, 32'h1000, 16, 16, rx);
    checks++; if (rx[15:0] !== 16'h0) begin errors++; $display("FAIL rb_oob got=%h exp=0000", rx[15:0]); end
    checks++; if (bus0.CIPO !== 1'b0) begin errors++; $display("FAIL rb_cs_high_cipo got=%b exp=0", bus0.CIPO); end
  endtask

  task automatic test_abort();
    logic [31:0] rx;
    int s0;
    s0 = stb0_cnt;
    spi_xfer(0, 32'h8155, 16, 10, rx);
    checks++; if (regs_out0 !== 40'h3C00A50000) begin errors++; $display("FAIL abort_regs got=%h exp=3c00a50000", regs_out0); end
    checks++; if (stb0_cnt - s0 !== 0) begin errors++; $display("FAIL abort_stb got=%0d exp=0", stb0_cnt - s0); end
    spi_xfer(0, 32'h8155, 16, 16, rx);
    checks++; if (regs_out0 !== 40'h3C00A55500) begin errors++; $display("FAIL abort_retry got=%h exp=3c00a55500", regs_out0); end
    checks++; if (stb0_cnt - s0 !== 1) begin errors++; $display("FAIL abort_retry_stb got=%0d exp=1", stb0_cnt - s0); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rx;
    int s0;
    s0 = stb0_cnt;
    fork
      spi_xfer(0, 32'h8377, 16, 16, rx);
      begin
        #1275ns;
        rst_n = 1'b0;
        #1ns;
        checks++; if (regs_out0 !== 40'h0) begin errors++; $display("FAIL rstmid_regs got=%h exp=0", regs_out0); end
        checks++; if (wr_addr0 !== 7'h0) begin errors++; $display("FAIL rstmid_addr got=%h exp=0", wr_addr0); end
        checks++; if (wr_stb0 !== 1'b0) begin errors++; $display("FAIL rstmid_stb got=%b exp=0", wr_stb0); end
        checks++; if (bus0.CIPO !== 1'b0) begin errors++; $display("FAIL rstmid_cipo got=%b exp=0", bus0.CIPO); end
        #4ns;
        rst_n = 1'b1;
      end
    join
    checks++; if (stb0_cnt - s0 !== 0) begin errors++; $display("FAIL rstmid_nocommit got=%0d exp=0", stb0_cnt - s0); end
    checks++; if (regs_out0 !== 40'h0) begin errors++; $display("FAIL rstmid_after got=%h exp=0", regs_out0); end
    spi_xfer(0, 32'h8377, 16, 16, rx);
    checks++; if (regs_out0 !== 40'h0077000000) begin errors++; $display("FAIL rstmid_next got=%h exp=0077000000", regs_out0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    int s0;
    s0 = stb0_cnt;
    spi_xfer(0, 32'h8011, 16, 16, rx);
    spi_xfer(0, 32'h8122, 16, 16, rx);
    checks++; if (regs_out0 !== 40'h0077002211) begin errors++; $display("FAIL b2b_regs got=%h exp=0077002211", regs_out0); end
    checks++; if (stb0_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_stb got=%0d exp=2", stb0_cnt - s0); end
  endtask

  task automatic test_extra_bits();
    logic [31:0] rx;
    int s0;
    s0 = stb0_cnt;
    spi_xfer(0, 32'h825AF, 20, 20, rx);
    checks++; if (regs_out0 !== 40'h00775A2211) begin errors++; $display("FAIL extra_regs got=%h exp=00775a2211", regs_out0); end
    checks++; if (stb0_cnt - s0 !== 1) begin errors++; $display("FAIL extra_stb got=%0d exp=1", stb0_cnt - s0); end
  endtask

  task automatic test_wide();
    logic [31:0] rx;
    int s1;
    s1 = stb1_cnt;
    spi_xfer(1, 32'h1FBEEF, 21, 21, rx);
    checks++; if (regs_out1[255:240] !== 16'hBEEF) begin errors++; $display("FAIL wide_reg15 got=%h exp=beef", regs_out1[255:240]); end
    checks++; if (regs_out1[239:0] !== 240'h0) begin errors++; $display("FAIL wide_others got=%h exp=0", regs_out1[239:0]); end
    checks++; if (wr_addr1 !== 4'hF) begin errors++; $display("FAIL wide_addr got=%h exp=f", wr_addr1); end
    checks++; if (stb1_cnt - s1 !== 1) begin errors++; $display("FAIL wide_stb got=%0d exp=1", stb1_cnt - s1); end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus0.cs   = 1'b1; bus0.sclk = 1'b0; bus0.COPI = 1'b0;
    bus1.cs   = 1'b1; bus1.sclk = 1'b0; bus1.COPI = 1'b0;
    test_reset();
    test_write();
    test_write_oob();
    test_readback();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    test_extra_bits();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 Parameter NUM_REGS, default 5, number of implemented registers (1..2**ADDR_W).
REQ-002 Parameter ADDR_W, default 7, address field width in bits.
REQ-003 Parameter DATA_W, default 8, register width in bits.
REQ-004 Port clk input 1, single system clock; all logic is clocked on its rising edge.
REQ-005 Port rst_n input 1, asynchronous active-low reset.
REQ-006 Port sclk input 1, SPI serial clock, asynchronous to clk.
REQ-007 Port COPI input 1, SPI controller-out data, asynchronous to clk.
REQ-008 Port cs input 1, SPI chip select, active-low, asynchronous to clk.
REQ-009 Port CIPO output 1, SPI peripheral-out data.
REQ-010 Port regs_out output NUM_REGS*DATA_W, flattened registers; register n occupies bits [n*DATA_W +: DATA_W].
REQ-011 Port wr_stb output 1, one-clk pulse marking a committed write.
REQ-012 Port wr_addr output ADDR_W, address of the last committed write.

Function
REQ-013 sclk, COPI and cs shall each pass through a 2-flop synchroniser plus one history flop; edges are detected from the last two stages.
REQ-014 Protocol: SPI mode 0; COPI is sampled on detected sclk rising edges and CIPO changes on detected sclk falling edges; sclk frequency is at most clk/8.
REQ-015 Frame: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first, as {rw, addr, data}; rw=1 is write and rw=0 is read.
REQ-016 FSM states: IDLE, HDR, DATA, DONE.
REQ-017 IDLE->HDR: on synchronised cs falling edge; clears the bit counter and the shift register.
REQ-018 HDR->DATA: after 1+ADDR_W bits are captured; the address is latched.
REQ-019 DATA->DONE: after DATA_W further bits are captured.
REQ-020 DONE, write, addr<NUM_REGS: on the next clk the register is updated, wr_stb=1 for exactly one clk, and wr_addr=addr, all in the same cycle.
REQ-021 DONE, write, addr>=NUM_REGS: no register changes and wr_stb stays 0.
REQ-022 DONE: sclk edges are ignored until cs rises; extra bits shall not wrap the counter or alter any state.
REQ-023 Any state to IDLE on synchronised cs rising edge; a frame aborted before DONE shall commit nothing.
REQ-024 Read: on HDR->DATA the read shift register loads reg[addr], or 0 if addr>=NUM_REGS; CIPO presents its MSB on the next falling edge and shifts one bit per falling edge after that.
REQ-025 CIPO shall be 0 whenever cs is high, in IDLE, in HDR, and during write frames.
REQ-026 Simultaneous cs rise and final sclk rise detected in the same clk: the cs rise wins and the frame is aborted.
REQ-027 Back-to-back frames shall be accepted when cs stays high for at least 4 clk between frames.

Reset
REQ-028 rst_n low shall immediately force: all registers 0, regs_out 0, CIPO 0, wr_stb 0, wr_addr 0, FSM IDLE, counters and shift registers 0, synchroniser flops 0 except cs stages, which reset to 1.
REQ-029 Reset mid-frame shall discard the frame; after release, operation resumes at the next cs falling edge.

Configuration
REQ-030 Macro SPI_READBACK_EN defined: read frames behave per REQ-024.
REQ-031 Macro SPI_READBACK_EN undefined:
- CIPO is tied to 0.
- The read shift register is not built.
- Read frames complete without effect.

Verification
REQ-032 Write frame rw=1, addr=0x02, data=0xA5 (16 bits) -> reg2=0xA5; wr_stb pulses once with wr_addr=0x02; all other registers unchanged.
REQ-033 Write frame addr=0x7F, data=0xFF with NUM_REGS=5 -> regs_out unchanged; wr_stb never asserts.
REQ-034 With SPI_READBACK_EN defined, after writing reg4=0x3C, send read frame addr=0x04 -> CIPO bits 8..15 sampled by controller equal 0,0,1,1,1,1,0,0; CIPO=0 during bits 0..7.
REQ-035 cs raised after 10 bits of write frame addr=0x01, data=0x55 -> reg1 unchanged, no wr_stb; next full frame to 0x01 with 0x55 -> reg1=0x55.
REQ-036 rst_n pulsed low during bit 12 of a write frame -> all outputs 0 immediately; no commit after release; next frame commits normally.
REQ-037 Regression with ADDR_W=4, DATA_W=16, NUM_REGS=16: write frame addr=0xF, data=0xBEEF (21 bits) -> regs_out[255:240]=0xBEEF.
